// File: rtl/divider_pkg.sv
// rtl/divider_pkg.sv - shared state encoding and sizing helpers for the divider arbiter
package divider_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    // Width needed to index n items, never narrower than one bit.
    function automatic int clog2_min1(input int n);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

    localparam logic [63:0] ALL_ONES = '1;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin one-hot grant starting after last_grant
module rr_arbiter
    import divider_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int ID_W   = 2
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [ID_W-1:0]   last_grant,
    output logic [NUM_CH-1:0] gnt,
    output logic [ID_W-1:0]   gnt_idx,
    output logic              gnt_any
);

    int cand;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        cand    = 0;
        for (int k = 1; k <= NUM_CH; k++) begin
            cand = (int'(last_grant) + k) % NUM_CH;
            if (!gnt_any && req[cand]) begin
                gnt_any   = 1'b1;
                gnt[cand] = 1'b1;
                gnt_idx   = ID_W'(cand);
            end
        end
    end

endmodule

// File: rtl/divider_arbiter.sv
// rtl/divider_arbiter.sv - shares one unsigned iterative divider between NUM_CH requesters
module divider_arbiter
    import divider_pkg::*;
#(
    parameter  int NUM_CH  = 4,
    parameter  int WIDTH   = 16,
    parameter  int TIMEOUT = 64,
    localparam int ID_W    = clog2_min1(NUM_CH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CH-1:0]       req_valid,
    output logic [NUM_CH-1:0]       req_ready,
    input  logic [NUM_CH*WIDTH-1:0] req_numer,
    input  logic [NUM_CH*WIDTH-1:0] req_denom,
    output logic                    rsp_valid,
    output logic [ID_W-1:0]         rsp_id,
    output logic [WIDTH-1:0]        rsp_quot,
    output logic                    rsp_dz,
    output logic                    rsp_tmo,
    output logic                    div_start,
    output logic [WIDTH-1:0]        div_numer,
    output logic [WIDTH-1:0]        div_denom,
    input  logic                    div_quot_en,
    input  logic [WIDTH-1:0]        div_quot,
    output logic                    busy
);

    localparam int TW = clog2_min1(TIMEOUT);

    state_e            state_q, state_d;
    logic [ID_W-1:0]   last_q, last_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic [WIDTH-1:0]  numer_q, numer_d;
    logic [WIDTH-1:0]  denom_q, denom_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
    logic [WIDTH-1:0]  quot_q, quot_d;
    logic              dz_q, dz_d;
    logic              tmo_q, tmo_d;

    logic [NUM_CH-1:0] gnt;
    logic [ID_W-1:0]   gnt_idx;
    logic              gnt_any;
    logic [WIDTH-1:0]  sel_numer;
    logic [WIDTH-1:0]  sel_denom;

    rr_arbiter #(.NUM_CH(NUM_CH), .ID_W(ID_W)) u_rr (
        .req        (req_valid),
        .last_grant (last_q),
        .gnt        (gnt),
        .gnt_idx    (gnt_idx),
        .gnt_any    (gnt_any)
    );

    assign sel_numer = req_numer[int'(gnt_idx)*WIDTH +: WIDTH];
    assign sel_denom = req_denom[int'(gnt_idx)*WIDTH +: WIDTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            last_q   <= ID_W'(NUM_CH - 1);
            id_q     <= '0;
            numer_q  <= '0;
            denom_q  <= '0;
            timer_q  <= '0;
            rsp_id_q <= '0;
            quot_q   <= '0;
            dz_q     <= 1'b0;
            tmo_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            id_q     <= id_d;
            numer_q  <= numer_d;
            denom_q  <= denom_d;
            timer_q  <= timer_d;
            rsp_id_q <= rsp_id_d;
            quot_q   <= quot_d;
            dz_q     <= dz_d;
            tmo_q    <= tmo_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        id_d     = id_q;
        numer_d  = numer_q;
        denom_d  = denom_q;
        timer_d  = timer_q;
        rsp_id_d = rsp_id_q;
        quot_d   = quot_q;
        dz_d     = dz_q;
        tmo_d    = tmo_q;
        case (state_q)
            ST_IDLE: begin
                if (gnt_any) begin
                    last_d  = gnt_idx;
                    id_d    = gnt_idx;
                    numer_d = sel_numer;
                    denom_d = sel_denom;
                    dz_d    = 1'b0;
                    tmo_d   = 1'b0;
                    // A zero denominator is answered directly without touching the divider.
                    if (sel_denom == '0) begin
                        rsp_id_d = gnt_idx;
                        quot_d   = ALL_ONES[WIDTH-1:0];
                        dz_d     = 1'b1;
                        state_d  = ST_RESP;
                    end else begin
                        state_d  = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                timer_d = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                timer_d = timer_q + 1'b1;
                if (div_quot_en) begin
                    rsp_id_d = id_q;
                    quot_d   = div_quot;
                    state_d  = ST_RESP;
                end else if (timer_q == TW'(TIMEOUT - 1)) begin
                    rsp_id_d = id_q;
                    quot_d   = ALL_ONES[WIDTH-1:0];
                    tmo_d    = 1'b1;
                    state_d  = ST_RESP;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state_q == ST_IDLE && !rst) ? gnt : '0;
        div_start = (state_q == ST_ISSUE);
        rsp_valid = (state_q == ST_RESP);
        busy      = (state_q != ST_IDLE);
    end

    assign rsp_id    = rsp_id_q;
    assign rsp_quot  = quot_q;
    assign rsp_dz    = dz_q;
    assign rsp_tmo   = tmo_q;
    assign div_numer = numer_q;
    assign div_denom = denom_q;

endmodule

// File: tb/tb_divider_arbiter.sv
// tb/tb_divider_arbiter.sv - self-checking bench for divider_arbiter with a behavioural divider stub
module tb_divider_arbiter;

    localparam int NUM_CH  = 4;
    localparam int WIDTH   = 16;
    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [63:0] req_numer;
    logic [63:0] req_denom;
    logic        rsp_valid;
    logic [1:0]  rsp_id;
    logic [15:0] rsp_quot;
    logic        rsp_dz;
    logic        rsp_tmo;
    logic        div_start;
    logic [15:0] div_numer;
    logic [15:0] div_denom;
    logic        div_quot_en;
    logic [15:0] div_quot;
    logic        busy;

    divider_arbiter #(.NUM_CH(NUM_CH), .WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_numer(req_numer), .req_denom(req_denom),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_quot(rsp_quot),
        .rsp_dz(rsp_dz), .rsp_tmo(rsp_tmo),
        .div_start(div_start), .div_numer(div_numer), .div_denom(div_denom),
        .div_quot_en(div_quot_en), .div_quot(div_quot), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_fail = 0;

    // Divider stub: quotient_en pulses stub_lat cycles after the start cycle; 0 means never.
    int          stub_lat = 0;
    int          stub_cnt = 0;
    logic [15:0] stub_n = 16'd0;
    logic [15:0] stub_d = 16'd1;
    initial begin
        div_quot_en = 1'b0;
        div_quot    = 16'd0;
        forever begin
            @(negedge clk);
            if (div_start) begin
                stub_n   = div_numer;
                stub_d   = div_denom;
                stub_cnt = stub_lat;
            end
            @(posedge clk);
            #2;
            if (stub_cnt > 0) begin
                stub_cnt    = stub_cnt - 1;
                div_quot_en = (stub_cnt == 0);
            end else begin
                div_quot_en = 1'b0;
            end
            div_quot = div_quot_en ? stub_n / stub_d : 16'($urandom);
        end
    end

    int          o_ready_cnt, o_bad_ready, o_start_cnt, o_rsp_cnt;
    int          o_grant_cyc, o_start_cyc, o_rsp_cyc;
    logic [1:0]  o_id;
    logic [15:0] o_quot, o_dn, o_dd;
    logic        o_dz, o_tmo, o_dz_after;

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        req_valid = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Presents one request on channel ch and records what the DUT does over budget cycles.
    task automatic run_op(input int ch, input logic [15:0] n, input logic [15:0] d, input int budget);
        logic drop;
        drop = 1'b0;
        o_ready_cnt = 0; o_bad_ready = 0; o_start_cnt = 0; o_rsp_cnt = 0;
        o_grant_cyc = -100; o_start_cyc = -100; o_rsp_cyc = -100;
        o_id = '0; o_quot = '0; o_dn = '0; o_dd = '0; o_dz = 1'b0; o_tmo = 1'b0; o_dz_after = 1'bx;
        @(posedge clk); #1;
        req_numer[ch*16 +: 16] = n;
        req_denom[ch*16 +: 16] = d;
        req_valid = 4'b0001 << ch;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (cyc == o_grant_cyc + 1) o_dz_after = rsp_dz;
            if (req_ready != 4'b0000) begin
                o_ready_cnt++;
                if (req_ready != (4'b0001 << ch)) o_bad_ready++;
                o_grant_cyc = cyc;
                drop = 1'b1;
            end
            if (div_start) begin
                o_start_cnt++;
                o_start_cyc = cyc;
                o_dn = div_numer;
                o_dd = div_denom;
            end
            if (rsp_valid) begin
                o_rsp_cnt++;
                if (o_rsp_cnt == 1) begin
                    o_rsp_cyc = cyc; o_id = rsp_id; o_quot = rsp_quot; o_dz = rsp_dz; o_tmo = rsp_tmo;
                end
            end
            @(posedge clk); #1;
            if (drop) begin
                req_valid = '0;
                req_numer = {$urandom, $urandom};
                req_denom = {$urandom, $urandom};
                drop = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = '0;
        req_numer = '0;
        req_denom = '0;
        repeat (3) @(negedge clk);
        req_valid = 4'hF;
        #1;
        n_chk++;
        if (req_ready !== 4'b0000) begin
            n_fail++; $display("FAIL reset_ready: got %b expected 0000", req_ready);
        end
        n_chk++;
        if ({rsp_valid, rsp_id, rsp_quot, rsp_dz, rsp_tmo} !== '0) begin
            n_fail++; $display("FAIL reset_rsp: got v=%b id=%0d q=%h dz=%b tmo=%b expected all 0",
                               rsp_valid, rsp_id, rsp_quot, rsp_dz, rsp_tmo);
        end
        n_chk++;
        if ({div_start, div_numer, div_denom, busy} !== '0) begin
            n_fail++; $display("FAIL reset_div: got start=%b n=%h d=%h busy=%b expected all 0",
                               div_start, div_numer, div_denom, busy);
        end
        @(posedge clk); #1;
        req_valid = '0;
        rst = 1'b0;
    endtask

    task automatic test_single();
        stub_lat = 3;
        run_op(2, 16'd1000, 16'd7, 20);
        n_chk++;
        if (o_ready_cnt != 1 || o_bad_ready != 0) begin
            n_fail++; $display("FAIL single_ready: got %0d grants (%0d wrong) expected 1 on ch2", o_ready_cnt, o_bad_ready);
        end
        n_chk++;
        if (o_start_cnt != 1 || o_dn !== 16'd1000 || o_dd !== 16'd7) begin
            n_fail++; $display("FAIL single_start: got %0d starts n=%0d d=%0d expected 1 start n=1000 d=7",
                               o_start_cnt, o_dn, o_dd);
        end
        n_chk++;
        if (o_rsp_cnt != 1 || o_id !== 2'd2 || o_quot !== 16'd142 || o_dz !== 1'b0 || o_tmo !== 1'b0) begin
            n_fail++; $display("FAIL single_rsp: got cnt=%0d id=%0d q=%0d dz=%b tmo=%b expected cnt=1 id=2 q=142 dz=0 tmo=0",
                               o_rsp_cnt, o_id, o_quot, o_dz, o_tmo);
        end
        n_chk++;
        if (o_rsp_cyc - o_start_cyc != stub_lat + 1) begin
            n_fail++; $display("FAIL single_latency: got %0d cycles start->rsp expected %0d",
                               o_rsp_cyc - o_start_cyc, stub_lat + 1);
        end
    endtask

    task automatic test_div_zero();
        stub_lat = 3;
        run_op(1, 16'd55, 16'd0, 12);
        n_chk++;
        if (o_rsp_cnt != 1 || o_rsp_cyc != o_grant_cyc + 1) begin
            n_fail++; $display("FAIL dz_latency: got cnt=%0d grant@%0d rsp@%0d expected one rsp one cycle after grant",
                               o_rsp_cnt, o_grant_cyc, o_rsp_cyc);
        end
        n_chk++;
        if (o_id !== 2'd1 || o_quot !== 16'hFFFF || o_dz !== 1'b1 || o_tmo !== 1'b0) begin
            n_fail++; $display("FAIL dz_rsp: got id=%0d q=%h dz=%b tmo=%b expected id=1 q=ffff dz=1 tmo=0",
                               o_id, o_quot, o_dz, o_tmo);
        end
        n_chk++;
        if (o_start_cnt != 0) begin
            n_fail++; $display("FAIL dz_no_start: got %0d div_start pulses expected 0", o_start_cnt);
        end
    endtask

    task automatic test_timeout();
        int late_rsp;
        stub_lat = 0;
        run_op(3, 16'd100, 16'd5, 30);
        n_chk++;
        if (o_dz_after !== 1'b0) begin
            n_fail++; $display("FAIL tmo_dz_clear: got rsp_dz=%b after new grant expected 0", o_dz_after);
        end
        n_chk++;
        if (o_rsp_cnt != 1 || o_rsp_cyc != o_start_cyc + TIMEOUT + 1) begin
            n_fail++; $display("FAIL tmo_latency: got cnt=%0d start@%0d rsp@%0d expected rsp at start+%0d",
                               o_rsp_cnt, o_start_cyc, o_rsp_cyc, TIMEOUT + 1);
        end
        n_chk++;
        if (o_id !== 2'd3 || o_quot !== 16'hFFFF || o_tmo !== 1'b1 || o_dz !== 1'b0) begin
            n_fail++; $display("FAIL tmo_rsp: got id=%0d q=%h tmo=%b dz=%b expected id=3 q=ffff tmo=1 dz=0",
                               o_id, o_quot, o_tmo, o_dz);
        end
        @(posedge clk); #1;
        stub_cnt = 2;
        late_rsp = 0;
        repeat (8) begin
            @(negedge clk);
            if (rsp_valid || busy) late_rsp++;
        end
        n_chk++;
        if (late_rsp != 0) begin
            n_fail++; $display("FAIL tmo_late_quot: got %0d cycles with rsp_valid/busy expected 0", late_rsp);
        end
    endtask

    task automatic test_race();
        stub_lat = TIMEOUT;
        run_op(0, 16'd500, 16'd9, 30);
        n_chk++;
        if (o_rsp_cnt != 1 || o_rsp_cyc != o_start_cyc + TIMEOUT + 1) begin
            n_fail++; $display("FAIL race_latency: got cnt=%0d start@%0d rsp@%0d expected rsp at start+%0d",
                               o_rsp_cnt, o_start_cyc, o_rsp_cyc, TIMEOUT + 1);
        end
        n_chk++;
        if (o_quot !== 16'd55 || o_tmo !== 1'b0 || o_id !== 2'd0) begin
            n_fail++; $display("FAIL race_rsp: got id=%0d q=%0d tmo=%b expected id=0 q=55 tmo=0", o_id, o_quot, o_tmo);
        end
    endtask

    task automatic test_reset_mid();
        int stale;
        do_reset();
        stub_lat = 6;
        run_op(2, 16'd50, 16'd5, 3);
        n_chk++;
        if (o_start_cnt != 1) begin
            n_fail++; $display("FAIL rstmid_start: got %0d starts before reset expected 1", o_start_cnt);
        end
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        stale = 0;
        repeat (10) begin
            @(negedge clk);
            if (rsp_valid || busy) stale++;
        end
        n_chk++;
        if (stale != 0) begin
            n_fail++; $display("FAIL rstmid_stale: got %0d cycles with rsp_valid/busy expected 0", stale);
        end
        stub_lat = 3;
        run_op(0, 16'd9, 16'd3, 12);
        n_chk++;
        if (o_rsp_cnt != 1 || o_id !== 2'd0 || o_quot !== 16'd3 || o_tmo !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_next: got cnt=%0d id=%0d q=%0d tmo=%b expected cnt=1 id=0 q=3 tmo=0",
                               o_rsp_cnt, o_id, o_quot, o_tmo);
        end
    endtask

    task automatic test_fairness();
        logic [15:0] exp_q[$];
        logic [15:0] n_c, d_c;
        int ngrant, nrsp, g;
        logic refresh;
        do_reset();
        stub_lat = 2;
        ngrant = 0; nrsp = 0; g = 0; refresh = 1'b0;
        @(posedge clk); #1;
        for (int c = 0; c < 4; c++) begin
            req_numer[c*16 +: 16] = 16'($urandom);
            req_denom[c*16 +: 16] = 16'($urandom_range(1, 500));
        end
        req_valid = 4'hF;
        for (int k = 0; k < 300 && nrsp < 8; k++) begin
            @(negedge clk);
            if (req_ready != 4'b0000) begin
                n_chk++;
                if (req_ready != (4'b0001 << (ngrant % 4))) begin
                    n_fail++; $display("FAIL fair_grant%0d: got ready=%b expected one-hot ch%0d", ngrant, req_ready, ngrant % 4);
                end
                g = ngrant % 4;
                n_c = req_numer[g*16 +: 16];
                d_c = req_denom[g*16 +: 16];
                exp_q.push_back(n_c / d_c);
                ngrant++;
                refresh = 1'b1;
            end
            if (rsp_valid) begin
                n_chk++;
                if (rsp_id !== 2'(nrsp % 4) || exp_q.size() == 0 || rsp_quot !== exp_q[0]) begin
                    n_fail++; $display("FAIL fair_rsp%0d: got id=%0d q=%0d expected id=%0d q=%0d", nrsp, rsp_id, rsp_quot,
                                       nrsp % 4, exp_q.size() ? exp_q[0] : 16'd0);
                end
                if (exp_q.size() != 0) void'(exp_q.pop_front());
                nrsp++;
            end
            @(posedge clk); #1;
            if (refresh) begin
                req_numer[g*16 +: 16] = 16'($urandom);
                req_denom[g*16 +: 16] = 16'($urandom_range(1, 500));
                refresh = 1'b0;
            end
        end
        req_valid = '0;
        n_chk++;
        if (nrsp != 8) begin
            n_fail++; $display("FAIL fair_count: got %0d responses expected 8", nrsp);
        end
        repeat (10) @(posedge clk);
    endtask

    task automatic test_random();
        logic [3:0]  pend;
        logic [15:0] mn[4];
        logic [15:0] md[4];
        int          q_id[$];
        logic [15:0] q_quot[$];
        logic        q_dz[$];
        logic        q_tmo[$];
        int last_g, exp_g, lat, nrsp;
        logic outstanding, granted;
        do_reset();
        pend = '0; last_g = NUM_CH - 1; outstanding = 1'b0; granted = 1'b0; lat = 1; nrsp = 0; exp_g = 0;
        for (int c = 0; c < 4; c++) begin mn[c] = '0; md[c] = 16'd1; end
        for (int k = 0; k < 1500; k++) begin
            @(posedge clk); #1;
            if (granted) begin
                pend[exp_g] = 1'b0;
                stub_lat = lat;
                granted = 1'b0;
            end
            for (int c = 0; c < 4; c++) begin
                if (k < 1400 && !pend[c] && $urandom_range(0, 3) == 0) begin
                    pend[c] = 1'b1;
                    mn[c] = 16'($urandom);
                    md[c] = ($urandom_range(0, 5) == 0) ? 16'd0 : 16'($urandom_range(1, 700));
                end
                req_numer[c*16 +: 16] = mn[c];
                req_denom[c*16 +: 16] = md[c];
            end
            req_valid = pend;
            @(negedge clk);
            if (req_ready != 4'b0000 || (!outstanding && pend != 4'b0000)) begin
                exp_g = -1;
                for (int s = 1; s <= 4; s++) begin
                    if (exp_g < 0 && pend[(last_g + s) % 4]) exp_g = (last_g + s) % 4;
                end
                n_chk++;
                if (outstanding || exp_g < 0 || req_ready != (4'b0001 << exp_g)) begin
                    n_fail++; $display("FAIL rand_grant@%0d: got ready=%b expected ch%0d (busy_op=%b pend=%b)",
                                       cyc, req_ready, exp_g, outstanding, pend);
                end
                if (exp_g >= 0 && !outstanding) begin
                    last_g = exp_g;
                    outstanding = 1'b1;
                    granted = 1'b1;
                    case ($urandom_range(0, 9))
                        0:       lat = 0;
                        1:       lat = 20;
                        default: lat = $urandom_range(1, TIMEOUT);
                    endcase
                    q_id.push_back(exp_g);
                    if (md[exp_g] == 16'd0) begin
                        q_quot.push_back(16'hFFFF); q_dz.push_back(1'b1); q_tmo.push_back(1'b0);
                    end else if (lat >= 1 && lat <= TIMEOUT) begin
                        q_quot.push_back(mn[exp_g] / md[exp_g]); q_dz.push_back(1'b0); q_tmo.push_back(1'b0);
                    end else begin
                        q_quot.push_back(16'hFFFF); q_dz.push_back(1'b0); q_tmo.push_back(1'b1);
                    end
                end
            end
            if (rsp_valid) begin
                n_chk++;
                if (q_id.size() == 0) begin
                    n_fail++; $display("FAIL rand_rsp@%0d: got unexpected rsp id=%0d expected none", cyc, rsp_id);
                end else begin
                    if (rsp_id !== 2'(q_id[0]) || rsp_quot !== q_quot[0] || rsp_dz !== q_dz[0] || rsp_tmo !== q_tmo[0]) begin
                        n_fail++; $display("FAIL rand_rsp@%0d: got id=%0d q=%h dz=%b tmo=%b expected id=%0d q=%h dz=%b tmo=%b",
                                           cyc, rsp_id, rsp_quot, rsp_dz, rsp_tmo, q_id[0], q_quot[0], q_dz[0], q_tmo[0]);
                    end
                    void'(q_id.pop_front()); void'(q_quot.pop_front());
                    void'(q_dz.pop_front()); void'(q_tmo.pop_front());
                end
                outstanding = 1'b0;
                nrsp++;
            end
        end
        req_valid = '0;
        n_chk++;
        if (q_id.size() != 0 || outstanding || nrsp < 20) begin
            n_fail++; $display("FAIL rand_drain: got %0d pending results after %0d responses expected 0 pending, >=20 responses",
                               q_id.size(), nrsp);
        end
    endtask

    initial begin
        rst = 1'b1;
        req_valid = '0;
        req_numer = '0;
        req_denom = '0;
        test_reset();
        test_single();
        test_div_zero();
        test_timeout();
        test_race();
        test_reset_mid();
        test_fairness();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got simulation still running expected completion");
        $fatal(1);
    end

endmodule
